// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises one load/store request into single-byte accesses on a
// byte-wide RAM/IO bus. It returns a one-cycle ok pulse, and for loads the
// pulse carries the zero-extended little-endian word.
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [31:0] IO_ADDR_BOUND = 32'h30000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  ena_from_ls,
    input  logic [ADDR_WIDTH-1:0] addr_from_ls,
    input  logic [DATA_WIDTH-1:0] data_from_ls,
    input  logic                  wr_flag_from_ls,
    input  logic [2:0]            size_from_ls,
    input  logic                  rollback_flag_from_rob,
    output logic                  ok_flag_to_ls,
    output logic [DATA_WIDTH-1:0] data_to_ls,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] IO_BOUND = ADDR_WIDTH'(IO_ADDR_BOUND);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            n_q, n_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  ok_q, ok_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q, mem_wr_d;

    logic [2:0]            size_n_c;
    logic [2:0]            cap_idx_c;
    logic [DATA_WIDTH-1:0] buf_next_c;
    logic [7:0]            wbyte_c;
    logic                  io_stall_c;

    assign ok_flag_to_ls = ok_q;
    assign data_to_ls    = rdata_q;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign mem_wr        = mem_wr_q;

    // Byte count: sizes 0 and above 4 mean a full word.
    always_comb begin
        size_n_c = size_from_ls;
        if (size_from_ls == 3'd0 || size_from_ls > 3'd4) begin
            size_n_c = 3'd4;
        end
    end

    // Merge the incoming read byte into the assembly buffer; pick the store byte.
    always_comb begin
        cap_idx_c  = cnt_q - 3'd2;
        buf_next_c = buf_q;
        wbyte_c    = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (cap_idx_c == 3'(b)) begin
                buf_next_c[8*b +: 8] = mem_din;
            end
            if (cnt_q == 3'(b)) begin
                wbyte_c = data_q[8*b +: 8];
            end
        end
    end

    assign io_stall_c = (addr_q >= IO_BOUND) && io_buffer_full;

    // Next-state and registered-output logic; everything holds while rdy=0.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        ok_d       = ok_q;
        rdata_d    = rdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    ok_d     = 1'b0;
                    mem_wr_d = 1'b0;
                    if (ena_from_ls && wr_flag_from_ls) begin
                        addr_d  = addr_from_ls;
                        data_d  = data_from_ls;
                        n_d     = size_n_c;
                        state_d = S_WRITE;
                        if ((addr_from_ls >= IO_BOUND) && io_buffer_full) begin
                            cnt_d = 3'd0;
                        end else begin
                            mem_a_d    = addr_from_ls;
                            mem_dout_d = data_from_ls[7:0];
                            mem_wr_d   = 1'b1;
                            cnt_d      = 3'd1;
                        end
                    end else if (ena_from_ls && !rollback_flag_from_rob) begin
                        addr_d  = addr_from_ls;
                        n_d     = size_n_c;
                        state_d = S_READ;
                        mem_a_d = addr_from_ls;
                        cnt_d   = 3'd1;
                        buf_d   = '0;
                    end
                end
                S_READ: begin
                    mem_wr_d = 1'b0;
                    if (rollback_flag_from_rob) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        buf_d   = '0;
                    end else begin
                        if (cnt_q < n_q) begin
                            mem_a_d = addr_q + ADDR_WIDTH'(cnt_q);
                        end
                        if (cnt_q >= 3'd2) begin
                            buf_d = buf_next_c;
                        end
                        if (cnt_q == n_q + 3'd1) begin
                            rdata_d = buf_next_c;
                            ok_d    = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt_q < n_q) begin
                        if (io_stall_c) begin
                            mem_wr_d = 1'b0;
                        end else begin
                            mem_a_d    = addr_q + ADDR_WIDTH'(cnt_q);
                            mem_dout_d = wbyte_c;
                            mem_wr_d   = 1'b1;
                            cnt_d      = cnt_q + 3'd1;
                        end
                    end else begin
                        mem_wr_d = 1'b0;
                        ok_d     = 1'b1;
                        state_d  = S_IDLE;
                        cnt_d    = 3'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            n_q        <= 3'd0;
            cnt_q      <= 3'd0;
            buf_q      <= '0;
            ok_q       <= 1'b0;
            rdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            ok_q       <= ok_d;
            rdata_q    <= rdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed requests against a byte RAM model with a
// one-cycle registered read; an ok-pulse scoreboard checks data and timing.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ena_from_ls;
    logic [31:0] addr_from_ls;
    logic [31:0] data_from_ls;
    logic        wr_flag_from_ls;
    logic [2:0]  size_from_ls;
    logic        rollback_flag_from_rob;
    logic        ok_flag_to_ls;
    logic [31:0] data_to_ls;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .ena_from_ls            (ena_from_ls),
        .addr_from_ls           (addr_from_ls),
        .data_from_ls           (data_from_ls),
        .wr_flag_from_ls        (wr_flag_from_ls),
        .size_from_ls           (size_from_ls),
        .rollback_flag_from_rob (rollback_flag_from_rob),
        .ok_flag_to_ls          (ok_flag_to_ls),
        .data_to_ls             (data_to_ls),
        .mem_din                (mem_din),
        .mem_dout               (mem_dout),
        .mem_a                  (mem_a),
        .mem_wr                 (mem_wr),
        .io_buffer_full         (io_buffer_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]  ram [0:4095];
    logic [31:0] wlog_a[$];
    logic [7:0]  wlog_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: registered read, writes only on enabled cycles.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (rst && rdy && mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            wlog_a.push_back(mem_a);
            wlog_d.push_back(mem_dout);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each ok cycle consumes one expected completion.
    always @(negedge clk) begin
        if (rst && ok_flag_to_ls) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ok", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ok_cycle", 32'(cyc), 32'(e.cyc));
                chk("ok_data", data_to_ls, e.data);
            end
        end
    end

    task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] sz, output int acc);
        ena_from_ls     = 1'b1;
        wr_flag_from_ls = wr;
        addr_from_ls    = a;
        data_from_ls    = d;
        size_from_ls    = sz;
        acc             = cyc + 1;
        @(negedge clk);
        ena_from_ls = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ok"},   32'(ok_flag_to_ls), 32'd0);
        chk({tag, "_data"}, data_to_ls,         32'd0);
        chk({tag, "_a"},    mem_a,              32'd0);
        chk({tag, "_dout"}, 32'(mem_dout),      32'd0);
        chk({tag, "_wr"},   32'(mem_wr),        32'd0);
    endtask

    initial begin
        int          acc;
        logic [31:0] last_rd;
        logic [31:0] h_a;
        logic [7:0]  h_d;
        logic        h_w;
        exp_t        e;

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22;
        ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h010] = 8'h80; ram[12'h202] = 8'h5A;

        rst = 1'b0; rdy = 1'b1; ena_from_ls = 1'b0; addr_from_ls = '0;
        data_from_ls = '0; wr_flag_from_ls = 1'b0; size_from_ls = 3'd0;
        rollback_flag_from_rob = 1'b0; io_buffer_full = 1'b0;
        last_rd = 32'h0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // LW at 0x100: address trace then assembled word after 5 edges
        start_req(1'b0, 32'h100, 32'h0, 3'd4, acc);
        e.data = 32'h44332211; e.cyc = acc + 5; exp_q.push_back(e);
        chk("lw_a0", mem_a, 32'h100);
        chk("lw_wr0", 32'(mem_wr), 32'd0);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("lw_a", mem_a, 32'h100 + 32'(k));
            chk("lw_wr", 32'(mem_wr), 32'd0);
        end
        repeat (3) @(negedge clk);
        last_rd = 32'h44332211;

        // SH 0x200: two bytes, neighbour untouched, data_to_ls unchanged
        wlog_a.delete(); wlog_d.delete();
        start_req(1'b1, 32'h200, 32'hDEADBEEF, 3'd2, acc);
        e.data = last_rd; e.cyc = acc + 2; exp_q.push_back(e);
        repeat (3) @(negedge clk);
        chk("sh_nwrites", 32'(wlog_a.size()), 32'd2);
        if (wlog_a.size() == 2) begin
            chk("sh_a0", wlog_a[0], 32'h200); chk("sh_d0", 32'(wlog_d[0]), 32'hEF);
            chk("sh_a1", wlog_a[1], 32'h201); chk("sh_d1", 32'(wlog_d[1]), 32'hBE);
        end
        chk("sh_ram202", 32'(ram[12'h202]), 32'h5A);

        // SB to IO space with the buffer full across three edges
        wlog_a.delete(); wlog_d.delete();
        io_buffer_full = 1'b1;
        start_req(1'b1, 32'h30000, 32'h41, 3'd1, acc);
        e.data = last_rd; e.cyc = acc + 4; exp_q.push_back(e);
        chk("io_stall_wr0", 32'(mem_wr), 32'd0);
        @(negedge clk); chk("io_stall_wr1", 32'(mem_wr), 32'd0);
        @(negedge clk); chk("io_stall_wr2", 32'(mem_wr), 32'd0);
        io_buffer_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("io_nwrites", 32'(wlog_a.size()), 32'd1);
        if (wlog_a.size() == 1) begin
            chk("io_a", wlog_a[0], 32'h30000); chk("io_d", 32'(wlog_d[0]), 32'h41);
        end

        // LW aborted by rollback at E2, then LH at 0x101
        start_req(1'b0, 32'h100, 32'h0, 3'd4, acc);
        @(negedge clk);
        rollback_flag_from_rob = 1'b1;
        @(negedge clk);
        rollback_flag_from_rob = 1'b0;
        start_req(1'b0, 32'h101, 32'h0, 3'd2, acc);
        e.data = 32'h00003322; e.cyc = acc + 3; exp_q.push_back(e);
        repeat (4) @(negedge clk);
        last_rd = 32'h00003322;

        // Read accepted together with rollback is dropped
        rollback_flag_from_rob = 1'b1;
        start_req(1'b0, 32'h10, 32'h0, 3'd1, acc);
        rollback_flag_from_rob = 1'b0;
        repeat (4) @(negedge clk);

        // SW (size 0 means 4) frozen by rdy=0 for two edges
        wlog_a.delete(); wlog_d.delete();
        start_req(1'b1, 32'h300, 32'h04030201, 3'd0, acc);
        e.data = last_rd; e.cyc = acc + 6; exp_q.push_back(e);
        @(negedge clk);
        rdy = 1'b0;
        h_a = mem_a; h_d = mem_dout; h_w = mem_wr;
        chk("frz_a_pre", h_a, 32'h301);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("frz_a", mem_a, h_a);
            chk("frz_dout", 32'(mem_dout), 32'(h_d));
            chk("frz_wr", 32'(mem_wr), 32'(h_w));
        end
        rdy = 1'b1;
        repeat (5) @(negedge clk);
        chk("sw_nwrites", 32'(wlog_a.size()), 32'd4);
        if (wlog_a.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("sw_a", wlog_a[k], 32'h300 + 32'(k));
                chk("sw_d", 32'(wlog_d[k]), 32'(k + 1));
            end
        end

        // Reset in the middle of an LW, then LB at 0x10
        start_req(1'b0, 32'h100, 32'h0, 3'd4, acc);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        start_req(1'b0, 32'h10, 32'h0, 3'd1, acc);
        e.data = 32'h00000080; e.cyc = acc + 2; exp_q.push_back(e);
        repeat (5) @(negedge clk);

        chk("pending_ok", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
